// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the uart_phy slice.
// FSM state enums, frame width and the parity helper.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    T_IDLE   = 3'd0,
    T_START  = 3'd1,
    T_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    T_PARITY = 3'd3,
`endif
    T_STOP   = 3'd4
  } uart_tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE   = 3'd0,
    R_START  = 3'd1,
    R_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    R_PARITY = 3'd3,
`endif
    R_STOP   = 3'd4
  } uart_rx_state_t;

  // Even parity bit: XOR of the data bits.
  function automatic logic uart_parity(
    input logic [UART_DATA_BITS-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter.
// Ports: clk, rstn, start (restart at 0), half (half-period limit), tick.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic half,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] FULL = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2 - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // half shortens the current period so the following tick lands mid-bit.
  assign tick = (cnt_q == (half ? HALF : FULL));

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (start || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_phy.sv
// uart_phy: 8-bit UART transceiver, 1 start, 8 data LSB first, 1 stop.
// Ports: tx_valid/tx_data/tx_ready -> txd; rxd -> rx_valid/rx_data/rx_ready,
// error pulses rx_frame_err, rx_overrun, rx_parity_err.
// Define UART_PARITY_EN to add an even parity bit to both directions.
import uart_pkg::*;

module uart_phy #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      tx_valid,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  output logic                      tx_ready,
  output logic                      txd,
  input  logic                      rxd,
  output logic                      rx_valid,
  output logic [UART_DATA_BITS-1:0] rx_data,
  input  logic                      rx_ready,
  output logic                      rx_frame_err,
  output logic                      rx_overrun,
  output logic                      rx_parity_err
);

  localparam logic [2:0] LAST = 3'(UART_DATA_BITS - 1);

  // ---------------- TX ----------------
  uart_tx_state_t            tx_st_q, tx_st_d;
  logic [UART_DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic [2:0]                tx_idx_q, tx_idx_d;
  logic                      txd_q, txd_d;
  logic                      tx_go, tx_tick;
`ifdef UART_PARITY_EN
  logic                      tx_par_q, tx_par_d;
`endif

  assign tx_ready = (tx_st_q == T_IDLE);
  assign tx_go    = tx_valid & tx_ready;
  assign txd      = txd_q;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_tmr (
    .clk   (clk),
    .rstn  (rstn),
    .start (tx_go),
    .half  (1'b0),
    .tick  (tx_tick)
  );

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_sh_d  = tx_sh_q;
    tx_idx_d = tx_idx_q;
`ifdef UART_PARITY_EN
    tx_par_d = tx_par_q;
`endif
    unique case (tx_st_q)
      T_IDLE: if (tx_go) begin
        tx_sh_d  = tx_data;
        tx_idx_d = '0;
`ifdef UART_PARITY_EN
        tx_par_d = uart_parity(tx_data);
`endif
        tx_st_d  = T_START;
      end
      T_START: if (tx_tick) tx_st_d = T_DATA;
      T_DATA: if (tx_tick) begin
        tx_sh_d  = tx_sh_q >> 1;
        tx_idx_d = tx_idx_q + 3'd1;
        if (tx_idx_q == LAST) begin
`ifdef UART_PARITY_EN
          tx_st_d = T_PARITY;
`else
          tx_st_d = T_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      T_PARITY: if (tx_tick) tx_st_d = T_STOP;
`endif
      T_STOP: if (tx_tick) tx_st_d = T_IDLE;
      default: tx_st_d = T_IDLE;
    endcase

    // txd is registered from the next state so the line is glitch-free.
    txd_d = 1'b1;
    unique case (tx_st_d)
      T_START:  txd_d = 1'b0;
      T_DATA:   txd_d = tx_sh_d[0];
`ifdef UART_PARITY_EN
      T_PARITY: txd_d = tx_par_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_st_q  <= T_IDLE;
      tx_sh_q  <= '0;
      tx_idx_q <= '0;
      txd_q    <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q <= 1'b0;
`endif
    end else begin
      tx_st_q  <= tx_st_d;
      tx_sh_q  <= tx_sh_d;
      tx_idx_q <= tx_idx_d;
      txd_q    <= txd_d;
`ifdef UART_PARITY_EN
      tx_par_q <= tx_par_d;
`endif
    end
  end

  // ---------------- RX ----------------
  logic                      rx_s1_q, rx_s2_q, rx_prev_q;
  logic                      rxs, rx_fall;
  uart_rx_state_t            rx_st_q, rx_st_d;
  logic [UART_DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [2:0]                rx_idx_q, rx_idx_d;
  logic                      rx_start, rx_half, rx_tick;
  logic                      rx_done, rx_good, rx_acc, rx_perr;
  logic                      rx_valid_q, rx_valid_d;
  logic [UART_DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                      fe_q, fe_d, ov_q, ov_d, pe_q, pe_d;
`ifdef UART_PARITY_EN
  logic                      rx_perr_q, rx_perr_d;
  assign rx_perr = rx_perr_q;
`else
  assign rx_perr = 1'b0;
`endif

  assign rxs      = rx_s2_q;
  assign rx_fall  = rx_prev_q & ~rxs;
  assign rx_start = (rx_st_q == R_IDLE) & rx_fall;
  assign rx_half  = (rx_st_q == R_START);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_tmr (
    .clk   (clk),
    .rstn  (rstn),
    .start (rx_start),
    .half  (rx_half),
    .tick  (rx_tick)
  );

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_sh_d  = rx_sh_q;
    rx_idx_d = rx_idx_q;
    rx_done  = 1'b0;
`ifdef UART_PARITY_EN
    rx_perr_d = rx_perr_q;
`endif
    unique case (rx_st_q)
      R_IDLE: if (rx_fall) begin
        rx_idx_d = '0;
        rx_st_d  = R_START;
      end
      // A start bit that is high again at mid-bit was a glitch.
      R_START: if (rx_tick) rx_st_d = rxs ? R_IDLE : R_DATA;
      R_DATA: if (rx_tick) begin
        rx_sh_d  = {rxs, rx_sh_q[UART_DATA_BITS-1:1]};
        rx_idx_d = rx_idx_q + 3'd1;
        if (rx_idx_q == LAST) begin
`ifdef UART_PARITY_EN
          rx_st_d = R_PARITY;
`else
          rx_st_d = R_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      R_PARITY: if (rx_tick) begin
        rx_perr_d = rxs ^ uart_parity(rx_sh_q);
        rx_st_d   = R_STOP;
      end
`endif
      R_STOP: if (rx_tick) begin
        rx_done = 1'b1;
        rx_st_d = R_IDLE;
      end
      default: rx_st_d = R_IDLE;
    endcase
  end

  // Holding register: a byte completing alongside a handshake replaces it.
  always_comb begin
    rx_acc     = rx_valid_q & rx_ready;
    rx_good    = rx_done & rxs & ~rx_perr;
    rx_valid_d = rx_valid_q & ~rx_acc;
    rx_data_d  = rx_data_q;
    fe_d       = rx_done & ~rxs;
    pe_d       = rx_done & rx_perr;
    ov_d       = 1'b0;
    if (rx_good) begin
      if (!rx_valid_q || rx_acc) begin
        rx_data_d  = rx_sh_q;
        rx_valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= R_IDLE;
      rx_sh_q    <= '0;
      rx_idx_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
      pe_q       <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_st_q    <= rx_st_d;
      rx_sh_q    <= rx_sh_d;
      rx_idx_q   <= rx_idx_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
      pe_q       <= pe_d;
`ifdef UART_PARITY_EN
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end

  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign rx_frame_err  = fe_q;
  assign rx_overrun    = ov_q;
  assign rx_parity_err = pe_q;

endmodule
